// File: rtl/hilo_muldiv_if.sv
// hilo_muldiv_if: request, read-port and result bundle between ALU control (master) and hilo_muldiv_unit (slave)
interface hilo_muldiv_if #(
   parameter int WIDTH = 32
) ();
   logic             start;
   logic [1:0]       op;
   logic [WIDTH-1:0] src_a;
   logic [WIDTH-1:0] src_b;
   logic             flush;
   logic             rd_hi;
   logic             rd_lo;
   logic [WIDTH-1:0] rd_data;
   logic             stall;
   logic             busy;
   logic             done;
   logic             illegal_op;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
   modport master (
      output start, op, src_a, src_b, flush, rd_hi, rd_lo,
      input  rd_data, stall, busy, done, illegal_op, hi, lo
   );
   modport slave (
      input  start, op, src_a, src_b, flush, rd_hi, rd_lo,
      output rd_data, stall, busy, done, illegal_op, hi, lo
   );
endinterface

// File: rtl/hilo_muldiv_unit.sv
// hilo_muldiv_unit: one-bit-per-cycle MULTU/MULT/DIVU with atomic Hi/Lo commit; DIVU exists only when MULDIV_DIV_EN is defined
module hilo_muldiv_unit #(
   parameter int WIDTH = 32
) (
   input logic          clk,
   input logic          rst_n,
   hilo_muldiv_if.slave bus
);
   localparam int CNT_W = $clog2(WIDTH) + 1;
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [2*WIDTH-1:0] p_q, p_d, step, mul_step;
   logic [WIDTH-1:0]   opnd_q, opnd_d, hi_q, hi_d, lo_q, lo_d, mag_a, mag_b;
   logic [WIDTH:0]     sum;
   logic               neg_q, neg_d, done_q, done_d, ill_q, ill_d, go, legal, is_mult;
   assign is_mult = bus.op == 2'b01;
   // MULT runs on magnitudes; the most negative value maps onto its unsigned magnitude unchanged
   assign mag_a = (is_mult && bus.src_a[WIDTH-1]) ? -bus.src_a : bus.src_a;
   assign mag_b = (is_mult && bus.src_b[WIDTH-1]) ? -bus.src_b : bus.src_b;
   assign go = bus.start & ~bus.flush & (state_q != RUN);
   assign sum = {1'b0, p_q[2*WIDTH-1:WIDTH]} + {1'b0, {WIDTH{p_q[0]}} & opnd_q};
   assign mul_step = {sum, p_q[WIDTH-1:1]};
`ifdef MULDIV_DIV_EN
   logic             div_q, div_d, ge;
   logic [WIDTH:0]   trial;
   logic [WIDTH-1:0] rem;
   // restoring step: {rem, quo} shifts left, quotient bits enter at the bottom
   assign trial = {p_q[2*WIDTH-1:WIDTH], p_q[WIDTH-1]};
   assign ge = trial >= {1'b0, opnd_q};
   assign rem = ge ? WIDTH'(trial - {1'b0, opnd_q}) : trial[WIDTH-1:0];
   assign step = div_q ? {rem, p_q[WIDTH-2:0], ge} : mul_step;
   assign legal = bus.op != 2'b11;
`else
   assign step = mul_step;
   assign legal = !bus.op[1];
`endif
   always_comb begin
      state_d = state_q;
      cnt_d = cnt_q;
      p_d = p_q;
      opnd_d = opnd_q;
      neg_d = neg_q;
      hi_d = hi_q;
      lo_d = lo_q;
      done_d = 1'b0;
      ill_d = 1'b0;
`ifdef MULDIV_DIV_EN
      div_d = div_q;
`endif
      if (state_q == RUN) begin
         if (bus.flush) begin
            state_d = IDLE;
         end else begin
            p_d = step;
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CNT_W'(1)) begin
               {hi_d, lo_d} = neg_q ? -step : step;
               done_d = 1'b1;
               state_d = DONE;
            end
         end
      end else begin
         state_d = IDLE;
         ill_d = go & ~legal;
         if (go && legal) begin
            state_d = RUN;
            cnt_d = CNT_W'(WIDTH);
            neg_d = is_mult & (bus.src_a[WIDTH-1] ^ bus.src_b[WIDTH-1]);
            opnd_d = mag_a;
            p_d = {{WIDTH{1'b0}}, mag_b};
`ifdef MULDIV_DIV_EN
            div_d = bus.op[1];
            if (bus.op[1]) begin
               opnd_d = bus.src_b;
               p_d = {{WIDTH{1'b0}}, bus.src_a};
            end
`endif
         end
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q <= '0;
         p_q <= '0;
         opnd_q <= '0;
         neg_q <= 1'b0;
         hi_q <= '0;
         lo_q <= '0;
         done_q <= 1'b0;
         ill_q <= 1'b0;
`ifdef MULDIV_DIV_EN
         div_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q <= cnt_d;
         p_q <= p_d;
         opnd_q <= opnd_d;
         neg_q <= neg_d;
         hi_q <= hi_d;
         lo_q <= lo_d;
         done_q <= done_d;
         ill_q <= ill_d;
`ifdef MULDIV_DIV_EN
         div_q <= div_d;
`endif
      end
   end
   assign bus.busy = state_q == RUN;
   assign bus.done = done_q;
   assign bus.illegal_op = ill_q;
   assign bus.hi = hi_q;
   assign bus.lo = lo_q;
   assign bus.rd_data = bus.rd_hi ? hi_q : lo_q;
   assign bus.stall = (bus.rd_hi | bus.rd_lo) & (state_q == RUN);
endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// tb_hilo_muldiv_unit: directed corner cases plus random ops checked against an arithmetic reference model
module tb_hilo_muldiv_unit;
   localparam int W = 32;
   logic         clk = 1'b0;
   logic         rst_n = 1'b1;
   int           n_chk = 0;
   int           n_fail = 0;
   logic [W-1:0] exp_hi = '0;
   logic [W-1:0] exp_lo = '0;
   hilo_muldiv_if #(.WIDTH(W)) bus ();
   hilo_muldiv_unit #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   function automatic bit legal(input logic [1:0] o);
`ifdef MULDIV_DIV_EN
      return o != 2'b11;
`else
      return o == 2'b00 || o == 2'b01;
`endif
   endfunction
   function automatic logic [63:0] model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
      longint sa, sb;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      if (o == 2'b00) return {32'd0, a} * {32'd0, b};
      if (o == 2'b01) return 64'(sa * sb);
      return (b == 0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
   endfunction
   task automatic run_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b, input bit watch, input string tag);
      logic [63:0] r;
      int k;
      @(negedge clk);
      bus.start = 1'b1;
      bus.op = o;
      bus.src_a = a;
      bus.src_b = b;
      bus.rd_lo = watch;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      if (!legal(o)) begin
         chk({tag, " illegal_op"}, 64'(bus.illegal_op), 1);
         chk({tag, " busy"}, 64'(bus.busy), 0);
         chk({tag, " hi kept"}, 64'(bus.hi), 64'(exp_hi));
         chk({tag, " lo kept"}, 64'(bus.lo), 64'(exp_lo));
         @(posedge clk);
         #1;
         chk({tag, " illegal pulse"}, 64'(bus.illegal_op), 0);
         bus.rd_lo = 1'b0;
         return;
      end
      r = model(o, a, b);
      k = 1;
      while (k <= 100 && !bus.done && bus.busy) begin
         if (watch) begin
            chk({tag, " stall"}, 64'(bus.stall), 1);
            chk({tag, " rd_data old"}, 64'(bus.rd_data), 64'(exp_lo));
         end
         @(posedge clk);
         #1;
         k++;
      end
      chk({tag, " latency"}, 64'(k - 1), 64'(W));
      chk({tag, " done"}, 64'(bus.done), 1);
      exp_hi = r[63:32];
      exp_lo = r[31:0];
      chk({tag, " hi"}, 64'(bus.hi), 64'(exp_hi));
      chk({tag, " lo"}, 64'(bus.lo), 64'(exp_lo));
      if (watch) begin
         chk({tag, " stall on done"}, 64'(bus.stall), 0);
         chk({tag, " rd_data new"}, 64'(bus.rd_data), 64'(exp_lo));
      end
      @(posedge clk);
      #1;
      chk({tag, " done pulse"}, 64'(bus.done), 0);
      bus.rd_lo = 1'b0;
   endtask
   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
   initial begin
      int k;
      bit seen;
      logic [1:0] o;
      logic [W-1:0] a, b;
      bus.start = 1'b0;
      bus.op = 2'b00;
      bus.src_a = '0;
      bus.src_b = '0;
      bus.flush = 1'b0;
      bus.rd_hi = 1'b0;
      bus.rd_lo = 1'b1;
      #3 rst_n = 1'b0;
      #1;
      chk("reset hi", 64'(bus.hi), 0);
      chk("reset lo", 64'(bus.lo), 0);
      chk("reset busy", 64'(bus.busy), 0);
      chk("reset done", 64'(bus.done), 0);
      chk("reset illegal", 64'(bus.illegal_op), 0);
      chk("reset stall", 64'(bus.stall), 0);
      bus.rd_lo = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "multu max");
      chk("multu max hi const", 64'(bus.hi), 64'h0000_0000_FFFF_FFFE);
      chk("multu max lo const", 64'(bus.lo), 64'h1);
      run_op(2'b01, 32'hFFFF_FFFD, 32'd5, 0, "mult -3x5");
      chk("mult -3x5 hi const", 64'(bus.hi), 64'h0000_0000_FFFF_FFFF);
      chk("mult -3x5 lo const", 64'(bus.lo), 64'h0000_0000_FFFF_FFF1);
      run_op(2'b01, 32'h8000_0000, 32'h8000_0000, 0, "mult minxmin");
      chk("mult minxmin hi const", 64'(bus.hi), 64'h4000_0000);
      chk("mult minxmin lo const", 64'(bus.lo), 0);
      run_op(2'b10, 32'd100, 32'd7, 0, "divu 100/7");
`ifdef MULDIV_DIV_EN
      chk("divu 100/7 lo const", 64'(bus.lo), 14);
      chk("divu 100/7 hi const", 64'(bus.hi), 2);
`endif
      run_op(2'b10, 32'h1234, 32'd0, 0, "divu by 0");
`ifdef MULDIV_DIV_EN
      chk("divu by 0 lo const", 64'(bus.lo), 64'h0000_0000_FFFF_FFFF);
      chk("divu by 0 hi const", 64'(bus.hi), 64'h1234);
`endif
      run_op(2'b11, 32'd3, 32'd3, 0, "reserved op");
      run_op(2'b00, 32'hAAAA, 32'd1, 0, "preload");
      run_op(2'b00, 32'd3, 32'd4, 1, "rd_lo hold");
      chk("rd_lo hold lo const", 64'(bus.lo), 12);
      @(negedge clk);
      bus.start = 1'b1;
      bus.op = 2'b00;
      bus.src_a = 32'd7;
      bus.src_b = 32'd9;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      repeat (9) @(posedge clk);
      @(negedge clk);
      bus.flush = 1'b1;
      @(posedge clk);
      #1;
      bus.flush = 1'b0;
      chk("flush busy", 64'(bus.busy), 0);
      chk("flush done", 64'(bus.done), 0);
      seen = 1'b0;
      repeat (40) begin
         @(posedge clk);
         #1;
         seen |= bus.done | bus.busy;
      end
      chk("flush no later activity", 64'(seen), 0);
      chk("flush hi kept", 64'(bus.hi), 64'(exp_hi));
      chk("flush lo kept", 64'(bus.lo), 64'(exp_lo));
      @(negedge clk);
      bus.start = 1'b1;
      bus.flush = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      bus.flush = 1'b0;
      chk("flush beats start", 64'(bus.busy), 0);
      @(negedge clk);
      bus.start = 1'b1;
      bus.src_a = 32'd7;
      bus.src_b = 32'd9;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      repeat (4) @(negedge clk);
      bus.start = 1'b1;
      bus.src_a = 32'd5;
      bus.src_b = 32'd5;
      @(negedge clk);
      bus.start = 1'b0;
      k = 0;
      while (k < 100 && !bus.done) begin
         @(posedge clk);
         #1;
         k++;
      end
      chk("restart ignored done", 64'(bus.done), 1);
      chk("restart ignored lo", 64'(bus.lo), 63);
      chk("restart ignored hi", 64'(bus.hi), 0);
      exp_hi = '0;
      exp_lo = 32'd63;
      @(posedge clk);
      #1;
      @(negedge clk);
      bus.start = 1'b1;
      bus.src_a = 32'hFFFF;
      bus.src_b = 32'hFFFF;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      repeat (10) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("mid-run reset hi", 64'(bus.hi), 0);
      chk("mid-run reset lo", 64'(bus.lo), 0);
      chk("mid-run reset busy", 64'(bus.busy), 0);
      exp_hi = '0;
      exp_lo = '0;
      @(negedge clk);
      rst_n = 1'b1;
      run_op(2'b00, 32'h1234, 32'h10, 0, "after reset");
      for (int i = 0; i < 24; i++) begin
         o = 2'($urandom_range(0, 3));
         a = $urandom;
         case ($urandom_range(0, 5))
            0: b = '0;
            1: b = 32'h8000_0000;
            2: b = 32'hFFFF_FFFF;
            3: b = 32'($urandom_range(1, 20));
            default: b = $urandom;
         endcase
         run_op(o, a, b, i % 6 == 0, "random");
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/hilo_muldiv_unit.md
Name: hilo_muldiv_unit

Overview:
- Parametrised multi-cycle multiply/divide unit with architectural Hi/Lo registers, for the EX stage of the pipelined CPU.
- ALU control decodes MULTU/MULT/DIVU and MFHI/MFLO and drives this block's start/op/read strobes.
- The block iterates one bit per cycle, commits the result to Hi/Lo atomically, and raises a stall when Hi/Lo is read while an operation is in flight.

Parameters:
- WIDTH, 32, operand width; Hi and Lo are each WIDTH bits; must be >= 4.
- CNT_W, $clog2(WIDTH)+1, iteration counter width; derived, not overridden.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  launch the operation selected by op; sampled on the rising edge
- op  input  2  00 MULTU, 01 MULT (signed), 10 DIVU, 11 reserved
- src_a  input  WIDTH  multiplicand / dividend
- src_b  input  WIDTH  multiplier / divisor
- flush  input  1  abort the in-flight operation (branch/jump squash)
- rd_hi  input  1  MFHI request
- rd_lo  input  1  MFLO request
- rd_data  output  WIDTH  Hi if rd_hi, else Lo (combinational)
- stall  output  1  (rd_hi | rd_lo) & busy (combinational)
- busy  output  1  high while state is RUN
- done  output  1  one-cycle pulse on the edge that commits Hi/Lo
- illegal_op  output  1  one-cycle pulse when start carries an unsupported op
- hi  output  WIDTH  architectural Hi register
- lo  output  WIDTH  architectural Lo register

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; hi=0, lo=0, busy=0, done=0, illegal_op=0, counter=0, internal accumulators=0.
- States: IDLE, RUN, DONE.
- IDLE or DONE with start=1, legal op, flush=0: latch operands and op; counter=WIDTH; go to RUN.
- DONE lasts exactly one cycle, then goes to IDLE unless a new start is accepted.
- RUN: one iteration per edge, counter decrements. When counter reaches 0 on edge N+WIDTH (start sampled at edge N):
  - Write hi/lo.
  - done=1 for that cycle.
  - Go to DONE.
- busy is high for exactly WIDTH cycles per operation.
- start while in RUN: ignored, with no effect on the running operation.
- MULTU: unsigned shift-add. {hi,lo} = 2*WIDTH-bit product.
- MULT:
  - Take magnitudes of src_a and src_b; -2^(WIDTH-1) is handled as the unsigned magnitude 2^(WIDTH-1).
  - Multiply unsigned; two's-complement negate the 2*WIDTH-bit product if the operand signs differ.
  - The sign fix-up happens on the commit edge; no extra cycle.
- DIVU: restoring division. lo = quotient, hi = remainder.
  - Divisor 0: lo = all ones, hi = src_a; same latency.
- hi/lo are never partially updated; they hold old values until the commit edge.
- rd_data reflects the committed hi/lo. On the done cycle, rd_data shows the new value and stall=0.
- flush=1:
  - In RUN: return to IDLE on the next edge; hi/lo unchanged; no done pulse.
  - Same cycle as start: flush wins and the start is discarded.
  - In IDLE/DONE: no effect other than suppressing start.
- Unsupported op with start=1 and flush=0: illegal_op=1 for one cycle, state unchanged, hi/lo unchanged.
- Reset asserted mid-RUN: the operation is lost and all outputs return to reset values immediately.

Optional Feature:
- MULDIV_DIV_EN defined: DIVU (op=10) supported as above; only op=11 raises illegal_op.
- MULDIV_DIV_EN undefined: divider datapath is not built; op=10 and op=11 both raise illegal_op and are ignored. Multiply behaviour and latency are identical in both builds.

Test Plan:
- MULTU, src_a=src_b=0xFFFFFFFF (WIDTH=32):
  - busy for 32 cycles, done on the 32nd edge after start.
  - hi=0xFFFFFFFE, lo=0x00000001.
- MULT, src_a=0xFFFFFFFD (-3), src_b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1. MULT, 0x80000000 x 0x80000000 -> hi=0x40000000, lo=0.
- DIVU 100/7 -> lo=14, hi=2. DIVU 0x1234/0 -> lo=0xFFFFFFFF, hi=0x1234. With macro undefined: DIVU -> illegal_op pulse, busy stays 0.
- Preload lo=0xAAAA via MULTU 0xAAAA x 1, then start MULTU 3x4 and hold rd_lo=1:
  - stall=1 and rd_data=0xAAAA for cycles 1-32.
  - On the done cycle: stall=0, rd_data=12.
- start MULTU 7x9, flush on the 10th RUN cycle:
  - busy=0 next cycle, no done pulse, hi/lo keep prior values.
  - A second start issued during the first op's RUN is ignored.
- rst_n pulsed low mid-RUN -> hi=lo=0, busy=0 immediately. A start in the cycle after release completes normally.
